// File: rtl/matrix_pkg.sv
// Shared op codes, status codes and dispatcher state encoding for the matrix op units.
`ifndef ELEMENT_WIDTH
`define ELEMENT_WIDTH 16
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 8
`endif

package matrix_pkg;

    typedef enum logic [1:0] {
        OP_ADD        = 2'd0,
        OP_SCALAR_MUL = 2'd1,
        OP_TRANSPOSE  = 2'd2,
        OP_MUL        = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_BAD_DIM  = 2'd1,
        ST_BAD_ADDR = 2'd2,
        ST_TIMEOUT  = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_START,
        S_RUN,
        S_RELEASE,
        S_RESP
    } state_e;

    localparam int MAX_DIM = 16;

    function automatic logic dim_ok(input logic [4:0] d);
        return (d != 5'd0) && (int'(d) <= MAX_DIM);
    endfunction

endpackage

// File: rtl/matrix_mem_port_mux.sv
// Combinational NUM_OPS-to-1 selection of the shared BRAM port; zero added latency.
// When gate is low every output is forced to zero, so idle units cannot touch memory.
module matrix_mem_port_mux #(
    parameter int NUM_OPS       = 4,
    parameter int ADDR_WIDTH    = 8,
    parameter int ELEMENT_WIDTH = 16,
    parameter int SEL_WIDTH     = 2
) (
    input  logic                             gate,
    input  logic [SEL_WIDTH-1:0]             sel,
    input  logic [NUM_OPS-1:0]               u_rd_en,
    input  logic [NUM_OPS-1:0]               u_wr_en,
    input  logic [NUM_OPS*ADDR_WIDTH-1:0]    u_rd_addr,
    input  logic [NUM_OPS*ADDR_WIDTH-1:0]    u_wr_addr,
    input  logic [NUM_OPS*ELEMENT_WIDTH-1:0] u_wr_data,
    output logic                             mem_rd_en,
    output logic                             mem_wr_en,
    output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
    output logic [ADDR_WIDTH-1:0]            mem_wr_addr,
    output logic [ELEMENT_WIDTH-1:0]         mem_wr_data
);

    always_comb begin
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        if (gate) begin
            mem_rd_en   = u_rd_en[sel];
            mem_wr_en   = u_wr_en[sel];
            mem_rd_addr = u_rd_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wr_addr = u_wr_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wr_data = u_wr_data[sel*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        end
    end

endmodule

// File: rtl/matrix_op_dispatcher.sv
// Validates one matrix command at a time, runs the selected op unit through a level start/done
// handshake and lends it the BRAM port; error response 2 cycles after accept, no command queueing.
module matrix_op_dispatcher
    import matrix_pkg::*;
#(
    parameter int          ELEMENT_WIDTH  = `ELEMENT_WIDTH,
    parameter int          ADDR_WIDTH     = `BRAM_ADDR_WIDTH,
    parameter int          NUM_OPS        = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [1:0]                       cmd_op,
    input  logic [4:0]                       cmd_dim_m,
    input  logic [4:0]                       cmd_dim_n,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr_op1,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr_op2,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr_res,
    input  logic [7:0]                       cmd_scalar,
    output logic                             busy,
    output logic                             rsp_valid,
    output logic [1:0]                       rsp_status,
    output logic [NUM_OPS-1:0]               op_start,
    input  logic [NUM_OPS-1:0]               op_done,
    output logic [4:0]                       op_dim_m,
    output logic [4:0]                       op_dim_n,
    output logic [ADDR_WIDTH-1:0]            op_addr_op1,
    output logic [ADDR_WIDTH-1:0]            op_addr_op2,
    output logic [ADDR_WIDTH-1:0]            op_addr_res,
    output logic [7:0]                       op_scalar,
    input  logic [NUM_OPS-1:0]               u_rd_en,
    input  logic [NUM_OPS-1:0]               u_wr_en,
    input  logic [NUM_OPS*ADDR_WIDTH-1:0]    u_rd_addr,
    input  logic [NUM_OPS*ADDR_WIDTH-1:0]    u_wr_addr,
    input  logic [NUM_OPS*ELEMENT_WIDTH-1:0] u_wr_data,
    output logic                             mem_rd_en,
    output logic                             mem_wr_en,
    output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
    output logic [ADDR_WIDTH-1:0]            mem_wr_addr,
    output logic [ELEMENT_WIDTH-1:0]         mem_wr_data
);

    // Extra headroom so the footprint sum can never wrap for any legal dims.
    localparam int FW = ADDR_WIDTH + 11;

    state_e        state;
    logic [1:0]    op_sel;
    status_e       run_status;
    logic [15:0]   timer;
    logic [FW-1:0] res_end;
    logic          addr_ok;
    logic          mem_gate;

    assign res_end  = FW'(op_addr_res) + FW'(op_dim_m) * FW'(op_dim_n);
    assign addr_ok  = (res_end <= (FW'(1) << ADDR_WIDTH));
    assign mem_gate = (state == S_RUN) || (state == S_RELEASE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cmd_ready   <= 1'b0;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_status  <= ST_OK;
            run_status  <= ST_OK;
            op_start    <= '0;
            op_sel      <= 2'd0;
            timer       <= 16'd0;
            op_dim_m    <= 5'd0;
            op_dim_n    <= 5'd0;
            op_addr_op1 <= '0;
            op_addr_op2 <= '0;
            op_addr_res <= '0;
            op_scalar   <= 8'd0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        op_sel      <= cmd_op;
                        op_dim_m    <= cmd_dim_m;
                        op_dim_n    <= cmd_dim_n;
                        op_addr_op1 <= cmd_addr_op1;
                        op_addr_op2 <= cmd_addr_op2;
                        op_addr_res <= cmd_addr_res;
                        op_scalar   <= cmd_scalar;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!dim_ok(op_dim_m) || !dim_ok(op_dim_n)) begin
                        rsp_status <= ST_BAD_DIM;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else if (!addr_ok) begin
                        rsp_status <= ST_BAD_ADDR;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    op_start <= NUM_OPS'(1) << op_sel;
                    timer    <= 16'd0;
                    state    <= S_RUN;
                end
                S_RUN: begin
                    timer <= timer + 16'd1;
                    // A done arriving on the final timer cycle still counts as success.
                    if (op_done[op_sel]) begin
                        op_start   <= '0;
                        run_status <= ST_OK;
                        state      <= S_RELEASE;
                    end else if (timer == TIMEOUT_CYCLES - 16'd1) begin
                        op_start   <= '0;
                        run_status <= ST_TIMEOUT;
                        state      <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!op_done[op_sel]) begin
                        rsp_status <= run_status;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    matrix_mem_port_mux #(
        .NUM_OPS       (NUM_OPS),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .ELEMENT_WIDTH (ELEMENT_WIDTH),
        .SEL_WIDTH     (2)
    ) u_mux (
        .gate        (mem_gate),
        .sel         (op_sel),
        .u_rd_en     (u_rd_en),
        .u_wr_en     (u_wr_en),
        .u_rd_addr   (u_rd_addr),
        .u_wr_addr   (u_wr_addr),
        .u_wr_data   (u_wr_data),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data)
    );

endmodule

// File: tb/tb_matrix_op_dispatcher.sv
// Directed bench: behavioural BRAM, scalar-mul unit, short add stub, noisy transpose stub, hung mul stub.
module tb_matrix_op_dispatcher;

    localparam int EW = 16;
    localparam int AW = 8;
    localparam int NO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [4:0]        cmd_dim_m = 5'd0, cmd_dim_n = 5'd0;
    logic [AW-1:0]     cmd_addr_op1 = '0, cmd_addr_op2 = '0, cmd_addr_res = '0;
    logic [7:0]        cmd_scalar = 8'd0;
    logic              busy, rsp_valid;
    logic [1:0]        rsp_status;
    logic [NO-1:0]     op_start, op_done;
    logic [4:0]        op_dim_m, op_dim_n;
    logic [AW-1:0]     op_addr_op1, op_addr_op2, op_addr_res;
    logic [7:0]        op_scalar;
    logic [NO-1:0]     u_rd_en, u_wr_en;
    logic [NO*AW-1:0]  u_rd_addr, u_wr_addr;
    logic [NO*EW-1:0]  u_wr_data;
    logic              mem_rd_en, mem_wr_en;
    logic [AW-1:0]     mem_rd_addr, mem_wr_addr;
    logic [EW-1:0]     mem_wr_data;

    matrix_op_dispatcher #(
        .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .NUM_OPS(NO), .TIMEOUT_CYCLES(16'd16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dim_m(cmd_dim_m), .cmd_dim_n(cmd_dim_n),
        .cmd_addr_op1(cmd_addr_op1), .cmd_addr_op2(cmd_addr_op2), .cmd_addr_res(cmd_addr_res),
        .cmd_scalar(cmd_scalar), .busy(busy), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
        .op_start(op_start), .op_done(op_done), .op_dim_m(op_dim_m), .op_dim_n(op_dim_n),
        .op_addr_op1(op_addr_op1), .op_addr_op2(op_addr_op2), .op_addr_res(op_addr_res),
        .op_scalar(op_scalar), .u_rd_en(u_rd_en), .u_wr_en(u_wr_en),
        .u_rd_addr(u_rd_addr), .u_wr_addr(u_wr_addr), .u_wr_data(u_wr_data),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_rd_addr(mem_rd_addr),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    // BRAM model, 1-cycle read latency; op1 region preloaded with 1..6 while in reset.
    logic [EW-1:0] mem [0:255];
    logic [EW-1:0] mem_rd_data;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i < 6) ? EW'(i + 1) : '0;
            mem_rd_data <= '0;
        end else begin
            if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
            if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        end
    end

    // Unit 1: scalar multiply, one read per cycle, write one cycle later.
    logic          s1_rd_en, s1_wr_en, s1_done;
    logic [8:0]    s1_idx, s1_ridx;
    logic [7:0]    s1_widx;
    logic [8:0]    s1_total;
    logic [AW-1:0] s1_rd_addr, s1_wr_addr;
    logic [EW-1:0] s1_wr_data;
    assign s1_total   = 9'(op_dim_m) * 9'(op_dim_n);
    assign s1_rd_addr = op_addr_op1 + s1_ridx[7:0];
    assign s1_wr_addr = op_addr_res + s1_widx;
    assign s1_wr_data = mem_rd_data * {8'h00, op_scalar};
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rd_en <= 1'b0; s1_wr_en <= 1'b0; s1_done <= 1'b0;
            s1_idx <= '0; s1_ridx <= '0; s1_widx <= '0;
        end else begin
            s1_wr_en <= s1_rd_en;
            s1_widx  <= s1_ridx[7:0];
            if (!op_start[1]) begin
                s1_rd_en <= 1'b0; s1_idx <= '0; s1_done <= 1'b0;
            end else if (s1_idx < s1_total) begin
                s1_rd_en <= 1'b1; s1_ridx <= s1_idx; s1_idx <= s1_idx + 9'd1;
            end else begin
                s1_rd_en <= 1'b0;
                if (!s1_rd_en && !s1_wr_en) s1_done <= 1'b1;
            end
        end
    end

    // Unit 0: add stub, done three cycles after start, dropped one cycle after start falls.
    logic [1:0] u0_cnt;
    logic       u0_done;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u0_cnt <= 2'd0; u0_done <= 1'b0;
        end else if (!op_start[0]) begin
            u0_cnt <= 2'd0; u0_done <= 1'b0;
        end else begin
            if (u0_cnt != 2'd3) u0_cnt <= u0_cnt + 2'd1;
            if (u0_cnt == 2'd2) u0_done <= 1'b1;
        end
    end

    // Unit 2 toggles its enables forever; unit 3 reads while started and never finishes.
    logic n2 = 1'b0;
    always @(posedge clk) n2 <= ~n2;

    assign u_rd_en   = {op_start[3], n2, s1_rd_en, 1'b0};
    assign u_wr_en   = {1'b0, n2, s1_wr_en, 1'b0};
    assign u_rd_addr = {8'h33, 8'h80, s1_rd_addr, 8'h00};
    assign u_wr_addr = {8'h00, 8'h80, s1_wr_addr, 8'h00};
    assign u_wr_data = {16'h0000, 16'hDEAD, s1_wr_data, 16'h0000};
    assign op_done   = {1'b0, 1'b0, s1_done, u0_done};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rsp_cnt = 0, wr_cnt = 0, idle_leak = 0, sel_leak = 0, multi = 0;
    int start_cyc [NO] = '{0, 0, 0, 0};
    always @(negedge clk) begin
        if (rsp_valid) rsp_cnt++;
        if (mem_wr_en) wr_cnt++;
        for (int k = 0; k < NO; k++) if (op_start[k]) start_cyc[k]++;
        if (cmd_ready && (mem_rd_en || mem_wr_en || mem_rd_addr != 0 || mem_wr_addr != 0 || mem_wr_data != 0))
            idle_leak++;
        if (op_start[1] && (mem_wr_en !== u_wr_en[1])) sel_leak++;
        if (!$onehot0(op_start)) multi++;
    end

    int tests = 0, fails = 0;
    int acc_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] m, input logic [4:0] n,
                         input logic [7:0] a1, input logic [7:0] ar, input logic [7:0] sc);
        int k = 0;
        while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
        check("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_dim_m = m; cmd_dim_n = n;
        cmd_addr_op1 = a1; cmd_addr_op2 = 8'h00; cmd_addr_res = ar; cmd_scalar = sc;
        cmd_valid = 1'b1;
        acc_cyc = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic [1:0] st, output logic b);
        logic seen = 1'b0;
        lat = 0; st = 2'd0; b = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1; lat = cyc - acc_cyc; st = rsp_status; b = busy;
            end
        end
        check("rsp_seen", 32'(seen), 32'd1);
    endtask

    int lat, r0, w0, s0, s1c, s2c, s3c;
    logic [1:0] st;
    logic b;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy_rsp", 32'({busy, rsp_valid, rsp_status}), 32'd0);
        check("rst_op_start", 32'(op_start), 32'd0);
        check("rst_op_fields", 32'({op_dim_m, op_dim_n, op_addr_res, op_scalar}), 32'd0);
        check("rst_mem", 32'({mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr}), 32'd0);
        check("rst_mem_data", 32'(mem_wr_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Scalar multiply 2x3 by 3 into 0x10
        r0 = rsp_cnt; s0 = start_cyc[0]; s2c = start_cyc[2]; s3c = start_cyc[3]; s1c = start_cyc[1];
        issue(2'd1, 5'd2, 5'd3, 8'h00, 8'h10, 8'd3);
        @(negedge clk);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_rsp(lat, st, b);
        check("smul_status", 32'(st), 32'd0);
        check("smul_latency", 32'(lat), 32'd15);
        check("smul_busy_at_rsp", 32'(b), 32'd1);
        @(negedge clk);
        check("smul_ready_after_resp", 32'({cmd_ready, busy}), 32'b10);
        check("smul_rsp_pulses", 32'(rsp_cnt - r0), 32'd1);
        for (int i = 0; i < 6; i++)
            check($sformatf("smul_mem_%0h", 16 + i), 32'(mem[16 + i]), 32'(3 * (i + 1)));
        check("smul_other_units_started", 32'(start_cyc[0] - s0 + start_cyc[2] - s2c + start_cyc[3] - s3c), 32'd0);
        check("smul_unit1_started", 32'(start_cyc[1] - s1c > 0), 32'd1);
        check("smul_noise_addr_untouched", 32'(mem[8'h80]), 32'd0);
        check("smul_sel_only", 32'(sel_leak), 32'd0);
        check("op_fields_latched", 32'({op_addr_res, op_scalar}), 32'h1003);

        // Dimension errors: no start, no writes, response 2 cycles after accept
        w0 = wr_cnt; s0 = start_cyc[0];
        issue(2'd0, 5'd0, 5'd3, 8'h00, 8'h20, 8'd0);
        wait_rsp(lat, st, b);
        check("dim_m0_status", 32'(st), 32'd1);
        check("dim_m0_latency", 32'(lat), 32'd2);
        issue(2'd0, 5'd2, 5'd17, 8'h00, 8'h20, 8'd0);
        wait_rsp(lat, st, b);
        check("dim_n17_status", 32'(st), 32'd1);
        check("dim_n17_latency", 32'(lat), 32'd2);
        issue(2'd0, 5'd0, 5'd3, 8'h00, 8'hFF, 8'd0);
        wait_rsp(lat, st, b);
        check("dim_priority_status", 32'(st), 32'd1);
        check("dim_no_start", 32'(start_cyc[0] - s0), 32'd0);
        check("dim_no_write", 32'(wr_cnt - w0), 32'd0);

        // Footprint: 0xFC+6 overflows, 0xFA+6 fits exactly
        issue(2'd0, 5'd2, 5'd3, 8'h00, 8'hFC, 8'd0);
        wait_rsp(lat, st, b);
        check("bad_addr_status", 32'(st), 32'd2);
        check("bad_addr_latency", 32'(lat), 32'd2);
        issue(2'd0, 5'd2, 5'd3, 8'h00, 8'hFA, 8'd0);
        wait_rsp(lat, st, b);
        check("exact_fit_status", 32'(st), 32'd0);
        check("exact_fit_latency", 32'(lat), 32'd9);

        // Timeout: hung unit 3, 16 RUN cycles
        s3c = start_cyc[3];
        issue(2'd3, 5'd2, 5'd2, 8'h00, 8'h40, 8'd0);
        wait_rsp(lat, st, b);
        check("timeout_status", 32'(st), 32'd3);
        check("timeout_latency", 32'(lat), 32'd20);
        check("timeout_start_cycles", 32'(start_cyc[3] - s3c), 32'd16);
        issue(2'd0, 5'd1, 5'd1, 8'h00, 8'h50, 8'd0);
        wait_rsp(lat, st, b);
        check("after_timeout_status", 32'(st), 32'd0);
        check("status_held", 32'(rsp_status), 32'd0);

        // Asynchronous reset mid-RUN
        issue(2'd3, 5'd1, 5'd1, 8'h00, 8'h60, 8'd0);
        repeat (5) @(negedge clk);
        check("pre_rst_running", 32'({op_start, busy, mem_rd_en}), 32'b1000_1_1);
        r0 = rsp_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_op_start", 32'(op_start), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_mem", 32'({mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("no_rsp_on_reset", 32'(rsp_cnt - r0), 32'd0);
        issue(2'd0, 5'd1, 5'd1, 8'h00, 8'h70, 8'd0);
        wait_rsp(lat, st, b);
        check("post_rst_status", 32'(st), 32'd0);
        check("post_rst_latency", 32'(lat), 32'd9);

        repeat (4) @(negedge clk);
        check("idle_mem_quiet", 32'(idle_leak), 32'd0);
        check("start_onehot", 32'(multi), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
